// File: rtl/deco_scan_pkg.sv
// Shared types and constants for the 3-bit decoder scan sequencer.
package deco_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam int POS_W = 3;
  localparam int NUM_POS = 8;
  localparam logic [POS_W-1:0] LAST_POS = 3'd7;

  function automatic logic [POS_W-1:0] pos_inc(input logic [POS_W-1:0] p);
    return p + 3'd1;
  endfunction

endpackage

// File: rtl/deco_scan_seq_dwell_timer.sv
// Loadable dwell down-counter; saturates at zero and reports both the
// current and the next-cycle zero condition.
module dwell_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         count,
  input  logic [W-1:0] load_val,
  output logic         zero,
  output logic         zero_next
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_next;

  // next count: load wins, otherwise decrement while non-zero
  always_comb begin
    w_cnt_next = r_cnt;
    if (load) begin
      w_cnt_next = load_val;
    end else if (count && (r_cnt != '0)) begin
      w_cnt_next = r_cnt - W'(1);
    end else begin
      w_cnt_next = r_cnt;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign zero      = (r_cnt == '0);
  assign zero_next = (w_cnt_next == '0);

endmodule

// File: rtl/deco_scan_seq.sv
// Scan sequencer driving a 3x8 decoder through positions 0..7 with a
// programmable dwell. Optional blank cycle between positions: DECO_SCAN_BLANK_EN.
module deco_scan_seq
  import deco_scan_pkg::*;
#(
  parameter int DWELL_W = 8,
  parameter int NUM_POS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [DWELL_W-1:0] dwell,
  output logic               x,
  output logic               y,
  output logic               z,
  output logic               en,
  output logic               busy,
  output logic               frame_done
);

  localparam logic [POS_W-1:0] W_LAST = 3'(NUM_POS - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [POS_W-1:0]   r_pos;
  logic [POS_W-1:0]   w_pos_next;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] w_dwell_next;
  logic               r_cont;
  logic               w_cont_next;
  logic               w_load;
  logic               w_count;
  logic [DWELL_W-1:0] w_load_val;
  logic               w_zero;
  logic               w_zero_next;
  logic [POS_W-1:0]   r_code;
  logic               r_en;
  logic               r_busy;
  logic               r_frame_done;

  dwell_timer #(.W(DWELL_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .count    (w_count),
    .load_val (w_load_val),
    .zero     (w_zero),
    .zero_next(w_zero_next)
  );

  // next-state, position and timer control
  always_comb begin
    w_state_next = r_state;
    w_pos_next   = r_pos;
    w_dwell_next = r_dwell;
    w_cont_next  = r_cont;
    w_load       = 1'b0;
    w_count      = 1'b0;
    w_load_val   = r_dwell;
    if (stop) begin
      w_state_next = IDLE;
      w_pos_next   = 3'd0;
      w_load       = 1'b1;
      w_load_val   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_state_next = SCAN;
            w_pos_next   = 3'd0;
            w_dwell_next = dwell;
            w_cont_next  = cont;
            w_load       = 1'b1;
            w_load_val   = dwell;
          end else begin
            w_state_next = IDLE;
          end
        end
        SCAN: begin
          if (!w_zero) begin
            w_count = 1'b1;
          end else if ((r_pos == W_LAST) && !r_cont) begin
            w_state_next = IDLE;
            w_pos_next   = 3'd0;
            w_load       = 1'b1;
            w_load_val   = '0;
          end else begin
            w_pos_next = pos_inc(r_pos);
`ifdef DECO_SCAN_BLANK_EN
            w_state_next = BLANK;
`else
            w_state_next = SCAN;
            w_load       = 1'b1;
`endif
          end
        end
        BLANK: begin
`ifdef DECO_SCAN_BLANK_EN
          // position already advanced while blanked; start its dwell now
          w_state_next = SCAN;
          w_load       = 1'b1;
`else
          w_state_next = IDLE;
          w_pos_next   = 3'd0;
`endif
        end
        default: begin
          w_state_next = IDLE;
          w_pos_next   = 3'd0;
        end
      endcase
    end
  end

  // state, latched configuration and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pos        <= 3'd0;
      r_dwell      <= '0;
      r_cont       <= 1'b0;
      r_code       <= 3'd0;
      r_en         <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pos        <= w_pos_next;
      r_dwell      <= w_dwell_next;
      r_cont       <= w_cont_next;
      r_code       <= w_pos_next;
      r_en         <= (w_state_next == SCAN);
      r_busy       <= (w_state_next != IDLE);
      r_frame_done <= (w_state_next == SCAN) && (w_pos_next == W_LAST) && w_zero_next;
    end
  end

  assign x          = r_code[2];
  assign y          = r_code[1];
  assign z          = r_code[0];
  assign en         = r_en;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_deco_scan_seq.sv
// Directed self-checking bench for deco_scan_seq (table plus multi-cycle sequences).
module tb_deco_scan_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       cont;
  logic [7:0] dwell;
  logic       x, y, z, en, busy, frame_done;

  int checks;
  int failures;

  typedef struct {
    logic       start;
    logic       stop;
    logic       cont;
    logic [7:0] dwell;
    logic [2:0] code;
    logic       en;
    logic       busy;
    logic       fd;
  } vec_t;

  vec_t tbl [0:11];

  deco_scan_seq #(.DWELL_W(8), .NUM_POS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .cont      (cont),
    .dwell     (dwell),
    .x         (x),
    .y         (y),
    .z         (z),
    .en        (en),
    .busy      (busy),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // outputs packed as {code[2:0], en, busy, frame_done}
  function automatic logic [5:0] pack_exp(input logic [2:0] c, input logic e,
                                          input logic b, input logic f);
    return {c, e, b, f};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] outs();
    return {x, y, z, en, busy, frame_done};
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    cont  = 1'b0;
    dwell = 8'd0;

    step();
    step();
    chk("reset_outs", 32'(outs()), 32'(pack_exp(3'd0, 1'b0, 1'b0, 1'b0)));
    rst = 1'b0;
    step();
    chk("idle_after_reset", 32'(outs()), 32'(pack_exp(3'd0, 1'b0, 1'b0, 1'b0)));

`ifndef DECO_SCAN_BLANK_EN
    // single frame, dwell 0, then start+stop and stop-only in IDLE
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'd0, 3'd0, 1'b1, 1'b1, 1'b0};
    for (int i = 1; i < 8; i++)
      tbl[i] = '{1'b0, 1'b0, 1'b0, 8'd0, 3'(i), 1'b1, 1'b1, (i == 7)};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 8'd5, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 8'd0, 3'd0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      start = tbl[i].start;
      stop  = tbl[i].stop;
      cont  = tbl[i].cont;
      dwell = tbl[i].dwell;
      step();
      chk($sformatf("table_%0d", i), 32'(outs()),
          32'(pack_exp(tbl[i].code, tbl[i].en, tbl[i].busy, tbl[i].fd)));
    end
    stop = 1'b0;

    // dwell 3, continuous: 4 cycles per code, frame_done every 32, then stop at code 5
    start = 1'b1; cont = 1'b1; dwell = 8'd3;
    for (int k = 0; k <= 85; k++) begin
      step();
      if (k == 0) begin
        start = 1'b0;
        cont  = 1'b0;
        dwell = 8'd0;
      end
      chk($sformatf("cont_k%0d", k), 32'(outs()),
          32'(pack_exp(3'((k / 4) % 8), 1'b1, 1'b1, ((k % 32) == 31))));
    end
    stop = 1'b1;
    step();
    chk("stop_at_pos5", 32'(outs()), 32'(pack_exp(3'd0, 1'b0, 1'b0, 1'b0)));
    stop = 1'b0;
    step();
    chk("stop_stays_idle", 32'(outs()), 32'(pack_exp(3'd0, 1'b0, 1'b0, 1'b0)));

    // dwell changed and start re-asserted mid-frame: both ignored
    start = 1'b1; dwell = 8'd2;
    for (int k = 0; k <= 24; k++) begin
      step();
      start = 1'b0;
      if (k == 4) begin
        dwell = 8'd9;
        start = 1'b1;
      end
      if (k < 24)
        chk($sformatf("latch_k%0d", k), 32'(outs()),
            32'(pack_exp(3'(k / 3), 1'b1, 1'b1, (k == 23))));
      else
        chk("latch_end_idle", 32'(outs()), 32'(pack_exp(3'd0, 1'b0, 1'b0, 1'b0)));
    end
    // restart picks up the new dwell of 9 -> 10 cycles per code
    start = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      step();
      start = 1'b0;
      chk($sformatf("relatch_k%0d", k), 32'(outs()),
          32'(pack_exp(3'(k / 10), 1'b1, 1'b1, 1'b0)));
    end
    stop = 1'b1;
    step();
    stop = 1'b0;

    // reset just before the frame_done cycle suppresses the pulse
    start = 1'b1; cont = 1'b1; dwell = 8'd0;
    for (int k = 0; k <= 6; k++) begin
      step();
      start = 1'b0;
    end
    chk("pre_reset_pos6", 32'(outs()), 32'(pack_exp(3'd6, 1'b1, 1'b1, 1'b0)));
    rst = 1'b1;
    step();
    chk("mid_reset", 32'(outs()), 32'(pack_exp(3'd0, 1'b0, 1'b0, 1'b0)));
    rst = 1'b0;
    step();
    chk("post_reset_idle", 32'(outs()), 32'(pack_exp(3'd0, 1'b0, 1'b0, 1'b0)));
`else
    // blank build: dwell 1 single frame -> 2 SCAN + 1 BLANK per code, 23 cycles
    start = 1'b1; cont = 1'b0; dwell = 8'd1;
    for (int k = 0; k <= 23; k++) begin
      step();
      start = 1'b0;
      if (k == 23)
        chk("blank_end_idle", 32'(outs()), 32'(pack_exp(3'd0, 1'b0, 1'b0, 1'b0)));
      else if ((k % 3) == 2)
        chk($sformatf("blank_k%0d", k), 32'(outs()),
            32'(pack_exp(3'((k / 3) + 1), 1'b0, 1'b1, 1'b0)));
      else
        chk($sformatf("blank_k%0d", k), 32'(outs()),
            32'(pack_exp(3'(k / 3), 1'b1, 1'b1, (k == 22))));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/deco_scan_seq.md
DECO_SCAN_SEQ -- requirements
Module: deco_scan_seq

Interface
REQ-001 SHALL have parameter DWELL_W, default 8, width of the dwell count.
REQ-002 SHALL have parameter NUM_POS, default 8, number of scan positions (fixed 8 for 3-bit code).
REQ-003 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-004 SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-005 SHALL have ports: start  in  1  begin scanning (level sampled each clk).
REQ-006 SHALL have ports: stop  in  1  abort scanning.
REQ-007 SHALL have ports: cont  in  1  1 = wrap continuously, 0 = single frame.
REQ-008 SHALL have ports: dwell  in  DWELL_W  cycles-per-position minus one.
REQ-009 SHALL have ports: x, y, z  out  1 each  3-bit code to downstream 3x8 decoder, x = MSB, z = LSB.
REQ-010 SHALL have ports: en  out  1  decoder enable.
REQ-011 SHALL have ports: busy  out  1  high in any non-IDLE state.
REQ-012 SHALL have ports: frame_done  out  1  one-cycle pulse at end of position 7.

Function
REQ-013 SHALL implement FSM states IDLE, SCAN, BLANK; all outputs registered.
REQ-014 IDLE: en=0, {x,y,z}=000, busy=0; start=1 and stop=0 -> SCAN next cycle.
REQ-015 On start acceptance SHALL latch dwell and cont; later changes ignored until next start.
REQ-016 SCAN: en=1, {x,y,z}=current position; each position held latched dwell+1 cycles (dwell=0 -> 1 cycle).
REQ-017 First SCAN cycle after start SHALL present position 000.
REQ-018 Position SHALL increment 0..7; after 7, wrap to 0 if latched cont=1, else go to IDLE.
REQ-019 frame_done SHALL be high exactly during the last cycle of position 7, otherwise 0.
REQ-020 stop=1 in any state SHALL force IDLE next cycle (en=0, code 000); stop overrides start on the same cycle.
REQ-021 start while busy SHALL be ignored.
REQ-022 dwell counter SHALL be DWELL_W bits, count down from latched dwell to 0, no overflow possible.
REQ-023 en SHALL never be high with a code other than the current position (no glitch positions).

Reset
REQ-024 rst SHALL take priority over all inputs, synchronous to clk.
REQ-025 During/after reset: state IDLE, x=y=z=0, en=0, busy=0, frame_done=0, counters 0, latched dwell 0, latched cont 0.
REQ-026 Reset asserted mid-frame SHALL return to IDLE on the next edge with no frame_done pulse.

Configuration
REQ-027 Macro DECO_SCAN_BLANK_EN SHALL, when defined, insert one BLANK cycle after every position (including 7 on wrap): en=0, code = next position.
REQ-028 With DECO_SCAN_BLANK_EN: frame = 8*(dwell+2) cycles; frame_done still on last SCAN cycle of position 7; single-frame mode goes to IDLE without trailing BLANK.
REQ-029 Without DECO_SCAN_BLANK_EN: BLANK state unreachable/absent, frame = 8*(dwell+1) cycles.

Structure
REQ-030 Package deco_scan_pkg SHALL hold state type (IDLE, SCAN, BLANK), POS_W=3, NUM_POS=8, LAST_POS=3'd7.
REQ-031 Dwell down-counter SHALL be sub-module dwell_timer (load, count, zero flag); FSM and position counter in top.

Verification
REQ-032 rst=1 2 cycles, then idle -> all outputs 0, busy=0.
REQ-033 dwell=0, cont=0, start pulse -> codes 0..7 on 8 consecutive cycles with en=1, frame_done on 8th, then IDLE en=0.
REQ-034 dwell=3, cont=1 -> each code held 4 cycles, frame_done every 32 cycles, 7 -> 0 wrap seamless.
REQ-035 cont=1 running, stop=1 at position 5 -> next cycle en=0, code 000, busy=0; start+stop same cycle in IDLE -> stays IDLE.
REQ-036 dwell changed 2->9 mid-frame -> hold stays 3 cycles until restart; start while busy has no effect.
REQ-037 DECO_SCAN_BLANK_EN defined, dwell=1, cont=0 -> pattern SCAN 2 cycles, BLANK 1 cycle (en=0) per position, 23 cycles total, IDLE after position 7.
